// File: rtl/button_conditioner_if.sv
// Raw push-button inputs and conditioned command outputs of the button conditioner.
// master drives the raw buttons; slave is the conditioner itself.
interface button_conditioner_if;
    logic       iBtnForward;
    logic       iBtnBack;
    logic       iBtnReset;
    logic       oForward;
    logic       oBack;
    logic       oClear;
    logic [2:0] oStable;

    modport master (
        output iBtnForward, iBtnBack, iBtnReset,
        input  oForward, oBack, oClear, oStable
    );

    modport slave (
        input  iBtnForward, iBtnBack, iBtnReset,
        output oForward, oBack, oClear, oStable
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects three panel buttons, then emits at most one
// single-cycle command pulse per cycle with priority reset > back > forward.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19
) (
    input logic                  iClk,
    input logic                  iReset,
    button_conditioner_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Channel index: 0 = forward, 1 = back, 2 = reset.
    logic [2:0]           w_raw;
    logic [2:0]           r_s1;
    logic [2:0]           r_s2;
    logic [2:0]           r_stable;
    logic [2:0]           r_stable_d;
    logic [CNT_WIDTH-1:0] r_cnt [3];
    logic [2:0]           w_rise;
    logic                 w_fwd_next;
    logic                 w_back_next;
    logic                 w_clr_next;
    logic                 r_forward;
    logic                 r_back;
    logic                 r_clear;

    assign w_raw = {bus.iBtnReset, bus.iBtnBack, bus.iBtnForward};

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_s1       <= w_raw;
            r_s2       <= r_s1;
            r_stable_d <= r_stable;
            // A disagreement must persist without a break; any agreement discards progress.
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = r_stable & ~r_stable_d;

    // Losing rises are dropped, not held for a later cycle.
    always_comb begin
        w_fwd_next  = 1'b0;
        w_back_next = 1'b0;
        w_clr_next  = 1'b0;
        if (w_rise[2])      w_clr_next  = 1'b1;
        else if (w_rise[1]) w_back_next = 1'b1;
        else if (w_rise[0]) w_fwd_next  = 1'b1;
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_forward <= 1'b0;
            r_back    <= 1'b0;
            r_clear   <= 1'b0;
        end else begin
            r_forward <= w_fwd_next;
            r_back    <= w_back_next;
            r_clear   <= w_clr_next;
        end
    end

    assign bus.oForward = r_forward;
    assign bus.oBack    = r_back;
    assign bus.oClear   = r_clear;
    assign bus.oStable  = r_stable;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4: a per-edge vector table
// plus hand-written sequences for hold-without-repeat and reset while a button is held.
module tb_button_conditioner;
  localparam int DB = 4;
  localparam int CW = 3;

  typedef struct {
    logic [2:0] btn;        // {reset, back, forward} raw levels applied before the edge
    logic       rst;
    logic [2:0] pulse_exp;  // {oClear, oBack, oForward} after the edge
    logic [2:0] stable_exp;
  } vec_t;

  logic iClk;
  logic iReset;
  int   n_vec;
  int   n_err;
  vec_t vecs[$];

  button_conditioner_if bus ();

  button_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW)) dut (
    .iClk   (iClk),
    .iReset (iReset),
    .bus    (bus.slave)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // driver tasks
  task automatic drive(input logic [2:0] btn, input logic rst);
    bus.iBtnReset   = btn[2];
    bus.iBtnBack    = btn[1];
    bus.iBtnForward = btn[0];
    iReset          = rst;
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic add(input logic [2:0] btn, input logic rst,
                     input logic [2:0] pulse, input logic [2:0] stable);
    vec_t v;
    v.btn = btn; v.rst = rst; v.pulse_exp = pulse; v.stable_exp = stable;
    vecs.push_back(v);
  endtask

  task automatic add_reset();
    add(3'b000, 1'b1, 3'b000, 3'b000);
    add(3'b000, 1'b1, 3'b000, 3'b000);
  endtask

  // scoreboard
  task automatic check(input string name, input logic [2:0] pulse_exp, input logic [2:0] stable_exp);
    logic [2:0] pulse_act;
    pulse_act = {bus.oClear, bus.oBack, bus.oForward};
    n_vec++;
    if (pulse_act !== pulse_exp || bus.oStable !== stable_exp) begin
      n_err++;
      $display("FAIL %s: pulses(clr,back,fwd)=%b stable=%b, required pulses=%b stable=%b",
               name, pulse_act, bus.oStable, pulse_exp, stable_exp);
    end
  endtask

  initial begin
    int pulses;
    n_vec = 0;
    n_err = 0;
    drive(3'b000, 1'b1);

    // reset state
    add_reset();
    // clean press: forward sampled from edge 0, held
    for (int e = 0; e < 12; e++)
      add(3'b001, 1'b0, (e == 6) ? 3'b001 : 3'b000, (e >= 5) ? 3'b001 : 3'b000);
    // release from edge 12: stable falls after edge 17, no pulse
    for (int e = 12; e < 21; e++)
      add(3'b000, 1'b0, 3'b000, (e < 17) ? 3'b001 : 3'b000);
    add_reset();
    // bounce on back, then held from edge 10
    for (int e = 0; e < 20; e++) begin
      logic [2:0] b;
      if (e < 4)       b = (e % 2 == 0) ? 3'b010 : 3'b000;
      else if (e < 10) b = 3'b000;
      else             b = 3'b010;
      add(b, 1'b0, (e == 16) ? 3'b010 : 3'b000, (e >= 15) ? 3'b010 : 3'b000);
    end
    add_reset();
    // simultaneous press: only clear wins
    for (int e = 0; e < 10; e++)
      add(3'b111, 1'b0, (e == 6) ? 3'b100 : 3'b000, (e >= 5) ? 3'b111 : 3'b000);
    add_reset();
    // staggered press: forward from edge 0, back from edge 3
    for (int e = 0; e < 13; e++) begin
      logic [2:0] p;
      logic [2:0] s;
      p = (e == 6) ? 3'b001 : (e == 9) ? 3'b010 : 3'b000;
      s = {1'b0, (e >= 8), (e >= 5)};
      add((e < 3) ? 3'b001 : 3'b011, 1'b0, p, s);
    end
    add_reset();
    // reset mid-debounce at edge 3: restart with k=4
    for (int e = 0; e < 13; e++)
      add(3'b001, (e == 3), (e == 10) ? 3'b001 : 3'b000, (e >= 9) ? 3'b001 : 3'b000);
    add_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].btn, vecs[i].rst);
      step();
      check($sformatf("vec%0d", i), vecs[i].pulse_exp, vecs[i].stable_exp);
    end

    // hold back for a long time: exactly one pulse, no auto-repeat
    pulses = 0;
    drive(3'b010, 1'b0);
    for (int e = 0; e < 60; e++) begin
      step();
      if (bus.oBack) pulses++;
      if (int'(bus.oClear) + int'(bus.oBack) + int'(bus.oForward) > 1) begin
        n_err++;
        $display("FAIL onehot: %b%b%b at hold edge %0d, required at most one high",
                 bus.oClear, bus.oBack, bus.oForward, e);
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL hold_pulses: %0d back pulses, required 1", pulses);
    end
    check("hold_stable", 3'b000, 3'b010);

    // reset button held across iReset: treated as new press after deassert
    drive(3'b100, 1'b1);
    step();
    check("held_rst_a", 3'b000, 3'b000);
    step();
    check("held_rst_b", 3'b000, 3'b000);
    drive(3'b100, 1'b0);
    for (int e = 0; e < 5; e++) step();
    check("held_edge4", 3'b000, 3'b000);
    step();
    check("held_edge5", 3'b000, 3'b100);
    step();
    check("held_edge6", 3'b100, 3'b100);
    step();
    check("held_edge7", 3'b000, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
